// File: rtl/aes_cbc_decryptor_if.sv
// Stream and key-load interfaces for the AES-128 CBC decryptor.
// Byte 0 of a block is data[127:120]; empty counts unused trailing bytes.
interface avalon_st_if;
   logic [127:0] data;
   logic         valid;
   logic         sop;
   logic         eop;
   logic [3:0]   empty;
   logic         rdy;

   modport master (output data, valid, sop, eop, empty, input rdy);
   modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

interface dvr_key_if;
   logic [127:0] key;
   logic [127:0] sync;
   logic         valid;
   logic         rdy;

   modport master (output key, sync, valid, input rdy);
   modport slave  (input key, sync, valid, output rdy);
endinterface

// File: rtl/aes_cbc_decryptor.sv
// AES-128 CBC decryptor: one key expansion per key/sync load, then one round per cycle.
// Optional mid-message re-key detection is built when AES_DEC_DOUBLE_SYNC_EN is defined.
package aes_model_pack;
   typedef logic [127:0] data_block;

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [2047:0] INV_SBOX_TBL = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   // Table byte x sits at offset (255-x)*8 from the LSB.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return INV_SBOX_TBL[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   function automatic data_block inv_subbytes(input data_block s);
      data_block o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
      return o;
   endfunction

   function automatic data_block inv_shift_rows(input data_block s);
      data_block o;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      return o;
   endfunction

   function automatic data_block inv_mix_columns(input data_block s);
      data_block  o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
         o[119 - 32*c -: 8] = gmul(a0, 4'd9) ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
         o[111 - 32*c -: 8] = gmul(a0, 4'd13) ^ gmul(a1, 4'd9) ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
         o[103 - 32*c -: 8] = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9) ^ gmul(a3, 4'd14);
      end
      return o;
   endfunction

   function automatic data_block key_expand(input data_block k, input logic [3:0] rnd);
      logic [31:0] t, n0, n1, n2, n3;
      logic [7:0]  rc;
      case (rnd)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
      n0 = k[127:96] ^ t;
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction
endpackage

module aes_cbc_decryptor
   import aes_model_pack::*;
(
   input  logic        clk,
   input  logic        rst,
   avalon_st_if.slave  msg_in,
   avalon_st_if.master msg_out,
   dvr_key_if.slave    key_and_sync,
   output logic        double_sync
);
   typedef enum logic [2:0] {IDLE, KEY_EXP, WAIT_BLK, DEC, OUT} state_t;

   state_t     state_reg, state_next;
   logic [3:0] cnt_reg, cnt_next;
   data_block  rk_reg [11];
   data_block  chain_reg, cur_c_reg, st_reg, out_data_reg;
   logic       sop_reg, eop_reg, out_valid_reg;
   logic [3:0] empty_reg;
   logic [10:0] rk_we;
   data_block  rk_cur, rk_prev, rk_new, inv_core, dec_round, dec_last;
   logic       key_fire, blk_fire;

   assign key_and_sync.rdy = rst && (state_reg == IDLE);
   assign msg_in.rdy       = rst && (state_reg == WAIT_BLK);
   assign key_fire         = key_and_sync.valid && key_and_sync.rdy;
   assign blk_fire         = msg_in.valid && msg_in.rdy;

   assign msg_out.valid = out_valid_reg;
   assign msg_out.data  = out_data_reg;
   assign msg_out.sop   = sop_reg;
   assign msg_out.eop   = eop_reg;
   assign msg_out.empty = empty_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE:
            if (key_fire) begin
               state_next = KEY_EXP;
               cnt_next   = 4'd1;
            end
         KEY_EXP:
            if (cnt_reg == 4'd10) begin
               state_next = WAIT_BLK;
               cnt_next   = 4'd0;
            end else begin
               cnt_next = cnt_reg + 4'd1;
            end
         WAIT_BLK:
            if (blk_fire) begin
               state_next = DEC;
               cnt_next   = 4'd9;
            end
         DEC:
            if (cnt_reg == 4'd0) state_next = OUT;
            else                 cnt_next   = cnt_reg - 4'd1;
         OUT:
            if (msg_out.rdy) state_next = eop_reg ? IDLE : WAIT_BLK;
         default: state_next = IDLE;
      endcase
   end

   // The counter selects both the key used this round and the one feeding expansion.
   always_comb begin
      rk_cur  = '0;
      rk_prev = '0;
      for (int i = 0; i < 11; i++) begin
         if (cnt_reg == 4'(i))         rk_cur  = rk_reg[i];
         if (cnt_reg == 4'(i) + 4'd1)  rk_prev = rk_reg[i];
      end
   end

   assign rk_new    = key_expand(rk_prev, cnt_reg);
   assign inv_core  = inv_subbytes(inv_shift_rows(st_reg));
   assign dec_round = inv_mix_columns(inv_core ^ rk_cur);
   assign dec_last  = inv_core ^ rk_reg[0];

   generate
      for (genvar gi = 0; gi < 11; gi++) begin : g_rk_we
         if (gi == 0) begin : g_load
            assign rk_we[gi] = key_fire;
         end else begin : g_expand
            assign rk_we[gi] = (state_reg == KEY_EXP) && (cnt_reg == 4'(gi));
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 11; i++) rk_reg[i] <= '0;
         chain_reg     <= '0;
         cur_c_reg     <= '0;
         st_reg        <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         sop_reg       <= 1'b0;
         eop_reg       <= 1'b0;
         empty_reg     <= 4'd0;
      end else begin
         for (int i = 0; i < 11; i++)
            if (rk_we[i]) rk_reg[i] <= (i == 0) ? key_and_sync.key : rk_new;
         case (state_reg)
            IDLE:
               if (key_fire) chain_reg <= key_and_sync.sync;
            WAIT_BLK:
               if (blk_fire) begin
                  cur_c_reg <= msg_in.data;
                  sop_reg   <= msg_in.sop;
                  eop_reg   <= msg_in.eop;
                  empty_reg <= msg_in.empty;
                  st_reg    <= msg_in.data ^ rk_reg[10];
               end
            DEC:
               if (cnt_reg == 4'd0) begin
                  st_reg        <= dec_last;
                  out_data_reg  <= dec_last ^ chain_reg;
                  out_valid_reg <= 1'b1;
               end else begin
                  st_reg <= dec_round;
               end
            OUT:
               if (msg_out.rdy) begin
                  chain_reg     <= cur_c_reg;
                  out_valid_reg <= 1'b0;
               end
            default: ;
         endcase
      end
   end

`ifdef AES_DEC_DOUBLE_SYNC_EN
   logic double_sync_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) double_sync_reg <= 1'b0;
      else      double_sync_reg <= key_and_sync.valid && (state_reg != IDLE);
   end

   assign double_sync = double_sync_reg;
`else
   assign double_sync = 1'b0;
`endif
endmodule

// File: tb/tb_aes_cbc_decryptor.sv
// Self-checking bench for aes_cbc_decryptor: FIPS-197 vectors plus random CBC messages
// whose ciphertext comes from a forward AES-CBC model with an algorithmically built S-box.
module tb_aes_cbc_decryptor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic double_sync;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   avalon_st_if msg_in_if ();
   avalon_st_if msg_out_if ();
   dvr_key_if   key_if ();

   aes_cbc_decryptor dut (
      .clk          (clk),
      .rst          (rst),
      .msg_in       (msg_in_if),
      .msg_out      (msg_out_if),
      .key_and_sync (key_if),
      .double_sync  (double_sync)
   );

   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CHAIN_PT = 128'h69d5c2eb2e2e624750541d3bbc692ba5;
`ifdef AES_DEC_DOUBLE_SYNC_EN
   localparam logic EXP_DS = 1'b1;
`else
   localparam logic EXP_DS = 1'b0;
`endif

   logic [7:0] tb_sbox [256];

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
      return (b << k) | (b >> (8 - k));
   endfunction

   // S-box = affine transform of the multiplicative inverse in GF(2^8).
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tb_sbox[tmp[23:16]], tb_sbox[tmp[15:8]], tb_sbox[tmp[7:0]], tb_sbox[tmp[31:24]]} ^ {rc, 24'h0};
            rc  = gm(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) t[i] = tb_sbox[s[i]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               t[4*c]   = gm(s[4*c], 2) ^ gm(s[4*c+1], 3) ^ s[4*c+2] ^ s[4*c+3];
               t[4*c+1] = s[4*c] ^ gm(s[4*c+1], 2) ^ gm(s[4*c+2], 3) ^ s[4*c+3];
               t[4*c+2] = s[4*c] ^ s[4*c+1] ^ gm(s[4*c+2], 2) ^ gm(s[4*c+3], 3);
               t[4*c+3] = gm(s[4*c], 3) ^ s[4*c+1] ^ s[4*c+2] ^ gm(s[4*c+3], 2);
            end
            for (int i = 0; i < 16; i++) s[i] = t[i];
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // lat = edges from the key handshake until msg_in.rdy, -1 on timeout.
   task automatic load_key(input logic [127:0] key, input logic [127:0] sync, output int lat);
      int n;
      lat = -1;
      n   = 0;
      while (key_if.rdy !== 1'b1 && n < 100) begin tick(); n++; end
      key_if.key   = key;
      key_if.sync  = sync;
      key_if.valid = 1'b1;
      tick();
      key_if.valid = 1'b0;
      n = 0;
      while (msg_in_if.rdy !== 1'b1 && n < 100) begin tick(); n++; end
      if (msg_in_if.rdy === 1'b1) lat = n;
   endtask

   task automatic drive_block(input logic [127:0] c, input logic sop, input logic eop, input logic [3:0] empty);
      int n;
      n = 0;
      while (msg_in_if.rdy !== 1'b1 && n < 100) begin tick(); n++; end
      msg_in_if.data  = c;
      msg_in_if.sop   = sop;
      msg_in_if.eop   = eop;
      msg_in_if.empty = empty;
      msg_in_if.valid = 1'b1;
      tick();
      msg_in_if.valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      int n;
      n = 0;
      while (msg_out_if.valid !== 1'b1 && n < 100) begin tick(); n++; end
      lat = (msg_out_if.valid === 1'b1) ? n : -1;
   endtask

   task automatic send_block(input logic [127:0] c, input logic sop, input logic eop, input logic [3:0] empty, output int lat);
      drive_block(c, sop, eop, empty);
      wait_out(lat);
      $display("txn in=%h sop=%0d eop=%0d empty=%0d -> out=%h lat=%0d", c, sop, eop, empty, msg_out_if.data, lat);
   endtask

   task automatic accept();
      msg_out_if.rdy = 1'b1;
      tick();
      msg_out_if.rdy = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      tick();
      tick();
      checks++;
      if ({key_if.rdy, msg_in_if.rdy, msg_out_if.valid, msg_out_if.sop, msg_out_if.eop, double_sync} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 000000", {key_if.rdy, msg_in_if.rdy, msg_out_if.valid, msg_out_if.sop, msg_out_if.eop, double_sync});
      end
      checks++;
      if (msg_out_if.data !== 128'h0 || msg_out_if.empty !== 4'h0) begin
         errors++;
         $display("FAIL reset_data: got %h/%h required 0/0", msg_out_if.data, msg_out_if.empty);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (key_if.rdy !== 1'b1 || msg_in_if.rdy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_rdy: got key_rdy=%b in_rdy=%b required 1/0", key_if.rdy, msg_in_if.rdy);
      end
      msg_in_if.data  = {$urandom, $urandom, $urandom, $urandom};
      msg_in_if.valid = 1'b1;
      tick();
      checks++;
      if (msg_in_if.rdy !== 1'b0 || msg_out_if.valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_stall: got in_rdy=%b out_valid=%b required 0/0", msg_in_if.rdy, msg_out_if.valid);
      end
      msg_in_if.valid = 1'b0;
   endtask

   task automatic test_fips();
      int lat;
      load_key(FIPS_KEY, 128'h0, lat);
      checks++;
      if (lat !== 10) begin errors++; $display("FAIL key_latency: got %0d required 10", lat); end
      send_block(FIPS_CT, 1'b1, 1'b1, 4'd0, lat);
      checks++;
      if (lat !== 10) begin errors++; $display("FAIL block_latency: got %0d required 10", lat); end
      checks++;
      if (msg_out_if.data !== FIPS_PT) begin errors++; $display("FAIL fips_data: got %h required %h", msg_out_if.data, FIPS_PT); end
      checks++;
      if ({msg_out_if.sop, msg_out_if.eop, msg_out_if.empty} !== 6'b110000) begin
         errors++;
         $display("FAIL fips_sideband: got %b required 110000", {msg_out_if.sop, msg_out_if.eop, msg_out_if.empty});
      end
      accept();
      checks++;
      if (key_if.rdy !== 1'b1 || msg_out_if.valid !== 1'b0) begin
         errors++;
         $display("FAIL fips_to_idle: got key_rdy=%b out_valid=%b required 1/0", key_if.rdy, msg_out_if.valid);
      end
   endtask

   task automatic test_cbc_chain();
      int lat;
      load_key(FIPS_KEY, 128'h0, lat);
      checks++;
      if (lat !== 10) begin errors++; $display("FAIL chain_key_latency: got %0d required 10", lat); end
      send_block(FIPS_CT, 1'b1, 1'b0, 4'd0, lat);
      checks++;
      if (msg_out_if.data !== FIPS_PT || lat !== 10) begin
         errors++;
         $display("FAIL chain_blk0: got %h lat %0d required %h lat 10", msg_out_if.data, lat, FIPS_PT);
      end
      accept();
      send_block(FIPS_CT, 1'b0, 1'b1, 4'd0, lat);
      checks++;
      if (msg_out_if.data !== CHAIN_PT || lat !== 10) begin
         errors++;
         $display("FAIL chain_blk1: got %h lat %0d required %h lat 10", msg_out_if.data, lat, CHAIN_PT);
      end
      accept();
   endtask

   task automatic test_iv();
      int lat;
      load_key(FIPS_KEY, FIPS_PT, lat);
      send_block(FIPS_CT, 1'b1, 1'b1, 4'd0, lat);
      checks++;
      if (msg_out_if.data !== 128'h0 || lat !== 10) begin
         errors++;
         $display("FAIL iv_applied: got %h lat %0d required 0 lat 10", msg_out_if.data, lat);
      end
      accept();
   endtask

   task automatic test_random_cbc();
      int           lat, nblk;
      logic [127:0] key, prev, pt, ct;
      logic [3:0]   empty;
      logic         sop, eop;
      for (int m = 0; m < 5; m++) begin
         key  = {$urandom, $urandom, $urandom, $urandom};
         prev = {$urandom, $urandom, $urandom, $urandom};
         nblk = $urandom_range(1, 4);
         load_key(key, prev, lat);
         checks++;
         if (lat !== 10) begin errors++; $display("FAIL rand_key_latency: msg %0d got %0d required 10", m, lat); end
         for (int b = 0; b < nblk; b++) begin
            pt    = {$urandom, $urandom, $urandom, $urandom};
            ct    = aes_enc(key, pt ^ prev);
            prev  = ct;
            empty = 4'($urandom_range(0, 15));
            sop   = (b == 0);
            eop   = (b == nblk - 1);
            send_block(ct, sop, eop, empty, lat);
            checks++;
            if (msg_out_if.data !== pt || lat !== 10) begin
               errors++;
               $display("FAIL rand_data: msg %0d blk %0d got %h lat %0d required %h lat 10", m, b, msg_out_if.data, lat, pt);
            end
            checks++;
            if ({msg_out_if.sop, msg_out_if.eop, msg_out_if.empty} !== {sop, eop, empty}) begin
               errors++;
               $display("FAIL rand_sideband: msg %0d blk %0d got %b required %b", m, b,
                        {msg_out_if.sop, msg_out_if.eop, msg_out_if.empty}, {sop, eop, empty});
            end
            repeat ($urandom_range(0, 3)) tick();
            accept();
         end
      end
   endtask

   task automatic test_back_pressure();
      int lat;
      load_key(FIPS_KEY, 128'h0, lat);
      send_block(FIPS_CT, 1'b1, 1'b0, 4'd3, lat);
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (msg_out_if.valid !== 1'b1 || msg_out_if.data !== FIPS_PT || msg_in_if.rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: cycle %0d got valid=%b data=%h in_rdy=%b required 1/%h/0",
                     i, msg_out_if.valid, msg_out_if.data, msg_in_if.rdy, FIPS_PT);
         end
      end
      accept();
      send_block(FIPS_CT, 1'b0, 1'b1, 4'd0, lat);
      checks++;
      if (msg_out_if.data !== CHAIN_PT || lat !== 10) begin
         errors++;
         $display("FAIL bp_next_block: got %h lat %0d required %h lat 10", msg_out_if.data, lat, CHAIN_PT);
      end
      accept();
   endtask

   task automatic test_double_sync();
      int lat;
      load_key(FIPS_KEY, 128'h0, lat);
      drive_block(FIPS_CT, 1'b1, 1'b1, 4'd0);
      tick();
      tick();
      tick();
      key_if.key   = ~FIPS_KEY;
      key_if.sync  = {128{1'b1}};
      key_if.valid = 1'b1;
      checks++;
      if (key_if.rdy !== 1'b0) begin errors++; $display("FAIL ds_key_rdy: got %b required 0", key_if.rdy); end
      tick();
      key_if.valid = 1'b0;
      checks++;
      if (double_sync !== EXP_DS) begin errors++; $display("FAIL ds_pulse: got %b required %b", double_sync, EXP_DS); end
      tick();
      checks++;
      if (double_sync !== 1'b0) begin errors++; $display("FAIL ds_one_cycle: got %b required 0", double_sync); end
      wait_out(lat);
      $display("txn in=%h sop=1 eop=1 empty=0 -> out=%h (re-key offered mid-block)", FIPS_CT, msg_out_if.data);
      checks++;
      if (msg_out_if.data !== FIPS_PT || lat < 0) begin
         errors++;
         $display("FAIL ds_result: got %h lat %0d required %h", msg_out_if.data, lat, FIPS_PT);
      end
      accept();
   endtask

   task automatic test_reset_mid_dec();
      int lat;
      load_key(FIPS_KEY, 128'h0, lat);
      drive_block(FIPS_CT, 1'b1, 1'b1, 4'd5);
      repeat (4) tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({key_if.rdy, msg_in_if.rdy, msg_out_if.valid, msg_out_if.sop, msg_out_if.eop, double_sync} !== 6'b0 ||
          msg_out_if.data !== 128'h0 || msg_out_if.empty !== 4'h0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got ctrl=%b data=%h empty=%h required all 0",
                  {key_if.rdy, msg_in_if.rdy, msg_out_if.valid, msg_out_if.sop, msg_out_if.eop, double_sync},
                  msg_out_if.data, msg_out_if.empty);
      end
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if (key_if.rdy !== 1'b1 || msg_in_if.rdy !== 1'b0 || msg_out_if.valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_idle: got key_rdy=%b in_rdy=%b valid=%b required 1/0/0",
                  key_if.rdy, msg_in_if.rdy, msg_out_if.valid);
      end
      load_key(FIPS_KEY, 128'h0, lat);
      send_block(FIPS_CT, 1'b1, 1'b1, 4'd0, lat);
      checks++;
      if (msg_out_if.data !== FIPS_PT || lat !== 10) begin
         errors++;
         $display("FAIL mid_reset_rekey: got %h lat %0d required %h lat 10", msg_out_if.data, lat, FIPS_PT);
      end
      accept();
   endtask

   initial begin
      msg_in_if.data   = '0;
      msg_in_if.valid  = 1'b0;
      msg_in_if.sop    = 1'b0;
      msg_in_if.eop    = 1'b0;
      msg_in_if.empty  = 4'd0;
      msg_out_if.rdy   = 1'b0;
      key_if.key       = '0;
      key_if.sync      = '0;
      key_if.valid     = 1'b0;
      build_sbox();
      test_reset();
      test_fips();
      test_cbc_chain();
      test_iv();
      test_random_cbc();
      test_back_pressure();
      test_double_sync();
      test_reset_mid_dec();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/aes_cbc_decryptor.md
# aes_cbc_decryptor

- Receive-side counterpart of the AES stream encryptor.
- Accepts a 128-bit key and sync (IV) on `dvr_key_if`, expands the AES-128 key schedule once, then decrypts Avalon-ST ciphertext blocks in CBC mode: plaintext = InvCipher(C) ^ previous C, with the IV as the first chain value.
- Sits between the link receiver and the plaintext consumer; uses an iterative one-round-per-cycle datapath built from `aes_model_pack` functions.

## Interface
- No parameters. Block width is fixed by `aes_model_pack::data_block` (128 bits). Byte 0 of the AES state is `data[127:120]`.
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- msg_in  avalon_st_if.slave  –  ciphertext in: data[127:0], valid, sop, eop, empty (inputs); rdy (output).
- msg_out  avalon_st_if.master  –  plaintext out: data, valid, sop, eop, empty (outputs); rdy (input).
- key_and_sync  dvr_key_if.slave  –  key[127:0], sync[127:0], valid (inputs); rdy (output).
- double_sync  output  1  one-cycle pulse when a key/sync arrives mid-message (see Configuration).

## Operation
- **States**
  - IDLE: key_and_sync.rdy=1. On valid&rdy: rk[0]<=key, chain<=sync, go to KEY_EXP.
  - KEY_EXP: 10 cycles, counter 1..10. rk[n] <= key_expand(rk[n-1], n). After n=10, go to WAIT_BLK.
  - WAIT_BLK: msg_in.rdy=1. On valid&rdy: cur_c<=data; capture sop/eop/empty; st<=data^rk[10]; go to DEC with counter=9.
  - DEC: 10 cycles.
    - Counter 9..1: st <= inv_mix_columns(inv_subbytes(inv_shift_rows(st)) ^ rk[counter]).
    - Counter 0: st <= inv_subbytes(inv_shift_rows(st)) ^ rk[0]; go to OUT.
  - OUT: msg_out.valid=1, data=st^chain, with the captured sop/eop/empty. On msg_out.rdy: chain<=cur_c. If eop=1, go to IDLE; otherwise go to WAIT_BLK.
- Round keys rk[0..10] (11×128 flops) are held for the whole message. The key schedule is recomputed only in IDLE→KEY_EXP.
- inv_subbytes, inv_shift_rows and inv_mix_columns are added to `aes_model_pack` alongside the existing forward functions.
- **Boundary cases**
  - key_and_sync.valid outside IDLE: ignored; rdy stays 0.
  - msg_in.valid outside WAIT_BLK: stalled; rdy stays 0, nothing captured.
  - empty is passed through unchanged. The full 128-bit block is always decrypted; empty never masks data.
  - sop is passed through only; it does not reset the chain. The chain resets only via a new key/sync.

## Timing
- **Reset values**: all outputs 0 while rst low (msg_in.rdy, key_and_sync.rdy, msg_out.valid/data/sop/eop/empty, double_sync). The state register is IDLE.
- **Ready and valid decode**
  - key_and_sync.rdy and msg_in.rdy are decoded from state and gated by rst, so they go to 1 in the first cycle after reset release.
  - msg_out.* are driven from registers. msg_out.valid is high exactly while in OUT.
- **Key load latency**: handshake at edge E0 → msg_in.rdy first high in the cycle after edge E10.
- **Block latency**: msg_in handshake at edge E0 → msg_out.valid high after edge E10. It holds, with data stable, until msg_out.rdy.
- **Throughput**: next msg_in.rdy the cycle after the output handshake, i.e. one block per ≥12 cycles.
- **Reset mid-operation**: immediate return to IDLE. Round keys, chain and any in-flight block are discarded. A new key/sync is required.

## Configuration
- **Macro**: `AES_DEC_DOUBLE_SYNC_EN`.
- **Defined**: double_sync pulses high for one cycle on every clk edge where key_and_sync.valid=1 and state≠IDLE. The offered key/sync is still ignored. This flags a sender re-keying mid-message.
- **Undefined**: double_sync is tied to 0; no detection logic is built.

## Test plan
- **FIPS-197 C.1 single block**
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, sync 0; one block 69c4e0d86a7b0430d8cdb78070b4c55a with sop=eop=1, empty=0.
  - Required: msg_out.data 00112233445566778899aabbccddeeff, valid 10 cycles after the input handshake. State returns to IDLE.
- **CBC chaining**
  - Stimulus: same key, sync 0; send the ciphertext above twice (sop, then eop).
  - Required: outputs 00112233445566778899aabbccddeeff, then 69d5c2eb2e2e624750541d3bbc692ba5.
- **IV applied**
  - Stimulus: sync 00112233445566778899aabbccddeeff; single ciphertext block as above.
  - Required: output all zeros.
- **Back-pressure**
  - Stimulus: hold msg_out.rdy=0 for 20 cycles in OUT.
  - Required: valid and data stable throughout, msg_in.rdy=0, the chain is not updated. The next block still decrypts correctly.
- **Double sync**
  - Stimulus: with the macro defined, pulse key_and_sync.valid during DEC.
  - Required: double_sync high for one cycle, key_and_sync.rdy=0, decryption result unchanged.
- **Reset mid-DEC**
  - Stimulus: assert rst at counter 5.
  - Required: all outputs 0, state IDLE. After re-keying, the FIPS vector decrypts correctly.
